// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with gapless back-to-back words.
// Optional even-parity trailer bit after each word when SER_PARITY_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing in flight, ready for a word
// S_SHIFT | data bit on x; r_cnt is the index of that bit (WIDTH-1..0)
// S_PAR   | parity trailer on x (SER_PARITY_EN builds only)
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic              r_x;
    logic              r_x_valid;
    logic              w_last;
    logic              w_accept;
`ifdef SER_PARITY_EN
    logic              r_par;
`endif

    assign w_last = (r_state == S_SHIFT) && (r_cnt == '0);

`ifdef SER_PARITY_EN
    assign din_ready = !rst && ((r_state == S_IDLE) || (r_state == S_PAR));
`else
    assign din_ready = !rst && ((r_state == S_IDLE) || w_last);
`endif

    assign w_accept = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= CW'(WIDTH - 1);
            r_shift   <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
`ifdef SER_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else if (w_accept) begin
            // MSB goes straight to x; the shifter keeps the remaining bits left-aligned
            r_state   <= S_SHIFT;
            r_cnt     <= CW'(WIDTH - 1);
            r_shift   <= {din[WIDTH-2:0], 1'b0};
            r_x       <= din[WIDTH-1];
            r_x_valid <= 1'b1;
`ifdef SER_PARITY_EN
            r_par     <= ^din;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (!w_last) begin
                        r_x     <= r_shift[WIDTH-1];
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        r_cnt   <= r_cnt - 1'b1;
                    end else begin
`ifdef SER_PARITY_EN
                        r_state <= S_PAR;
                        r_x     <= r_par;
`else
                        r_state   <= S_IDLE;
                        r_x       <= 1'b0;
                        r_x_valid <= 1'b0;
`endif
                    end
                end
`ifdef SER_PARITY_EN
                S_PAR: begin
                    r_state   <= S_IDLE;
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                end
`endif
                default: begin
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                end
            endcase
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign busy    = r_x_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: expected bits are queued at acceptance
// and popped as the serial stream appears. Define SER_PARITY_EN to cover the trailer.
module tb_bit_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = WIDTH + PAR;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int dut_acc = 0;
    bit sb[$];
    bit cap[$];

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (din_valid && din_ready) dut_acc++;

    // One clock: check ready against the model, queue accepted words, then check outputs.
    task automatic tick();
        bit exp_ready;
        bit exp_v;
        bit exp_x;
        #1;
        exp_ready = !rst && (sb.size() == 0);
        checks++;
        if (din_ready !== exp_ready) begin
            errors++;
            $display("FAIL din_ready: got %b want %b at %0t", din_ready, exp_ready, $time);
        end
        if (din_valid && exp_ready) begin
            for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(din[i]);
            if (PAR == 1) sb.push_back(^din);
        end
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        exp_x = 1'b0;
        if (rst) sb.delete();
        else if (sb.size() > 0) begin
            exp_x = sb.pop_front();
            exp_v = 1'b1;
        end
        checks++;
        if (x_valid !== exp_v || x !== exp_x || busy !== exp_v) begin
            errors++;
            $display("FAIL stream: got v=%b x=%b busy=%b want v=%b x=%b at %0t",
                     x_valid, x, busy, exp_v, exp_x, $time);
        end
        if (x_valid === 1'b1) cap.push_back(x);
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    function automatic logic [31:0] cap_word(input int first, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], cap[first + i]};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (dut_acc !== 0) begin
            errors++;
            $display("FAIL reset_accept: got %0d acceptances want 0", dut_acc);
        end
        rst = 1'b0;
        din_valid = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        cap.delete();
        send(8'hA5);
        idle(NB + 2);
        checks++;
        if (cap.size() !== NB) begin
            errors++;
            $display("FAIL single_len: got %0d bits want %0d", cap.size(), NB);
        end else if (cap_word(0, WIDTH) !== 32'hA5) begin
            errors++;
            $display("FAIL single_data: got %h want a5", cap_word(0, WIDTH));
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        cap.delete();
        acc0 = dut_acc;
        din = 8'h0F;
        din_valid = 1'b1;
        tick();
        for (int i = 0; i < NB + 4 && din_valid; i++) begin
            if (dut_acc - acc0 >= 1) din = 8'hF0;
            if (dut_acc - acc0 >= 2) din_valid = 1'b0;
            tick();
        end
        din_valid = 1'b0;
        idle(NB + 2);
        checks++;
        if (dut_acc - acc0 !== 2) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 2", dut_acc - acc0);
        end
        checks++;
        if (cap.size() !== 2 * NB) begin
            errors++;
            $display("FAIL b2b_len: got %0d bits want %0d", cap.size(), 2 * NB);
        end else if (cap_word(0, WIDTH) !== 32'h0F || cap_word(NB, WIDTH) !== 32'hF0) begin
            errors++;
            $display("FAIL b2b_data: got %h %h want 0f f0", cap_word(0, WIDTH), cap_word(NB, WIDTH));
        end
    endtask

    task automatic test_reset_mid();
        cap.delete();
        send(8'hFF);
        idle(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cap.size() !== 4) begin
            errors++;
            $display("FAIL mid_partial: got %0d bits before reset want 4", cap.size());
        end
        cap.delete();
        send(8'h81);
        idle(NB + 2);
        checks++;
        if (cap.size() !== NB || cap_word(0, WIDTH) !== 32'h81) begin
            errors++;
            $display("FAIL mid_recover: got %0d bits word %h want %0d bits 81",
                     cap.size(), cap_word(0, WIDTH), NB);
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        cap.delete();
        send(8'hA5);
        idle(NB + 1);
        send(8'h07);
        idle(NB + 1);
        checks++;
        if (cap.size() !== 2 * NB || cap[WIDTH] !== 1'b0 || cap[NB + WIDTH] !== 1'b1) begin
            errors++;
            $display("FAIL parity: got %0d bits trailers %b %b want 18 bits 0 1",
                     cap.size(), cap[WIDTH], cap[NB + WIDTH]);
        end
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] words[8];
        int acc0;
        int k;
        cap.delete();
        acc0 = dut_acc;
        for (int i = 0; i < 8; i++) words[i] = WIDTH'($urandom);
        k = 0;
        for (int c = 0; c < 400 && k < 8; c++) begin
            din = words[k];
            din_valid = ($urandom_range(0, 3) != 0);
            if (din_valid && sb.size() == 0) k++;
            tick();
        end
        din_valid = 1'b0;
        idle(NB + 2);
        checks++;
        if (dut_acc - acc0 !== 8 || cap.size() !== 8 * NB) begin
            errors++;
            $display("FAIL rand_len: got %0d words %0d bits want 8 words %0d bits",
                     dut_acc - acc0, cap.size(), 8 * NB);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap_word(i * NB, WIDTH) !== 32'(words[i])) begin
                    errors++;
                    $display("FAIL rand_word%0d: got %h want %h", i, cap_word(i * NB, WIDTH), words[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per word (legal range 2..32).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 din  input  WIDTH  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a word for transfer.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 x  output  1  serial bit stream feeding the downstream sequence detector's x input.
REQ-008 x_valid  output  1  x carries a meaningful bit this cycle.
REQ-009 busy  output  1  a word or its trailer bit is in flight.

Function
REQ-010 Transfer: a word is accepted on a rising edge where din_valid=1 and din_ready=1; din is not sampled otherwise.
REQ-011 Outputs x, x_valid and busy are registered; din_ready is combinational from state and bit counter only, never from din_valid.
REQ-012 States: IDLE, SHIFT, and PAR (PAR exists only with SER_PARITY_EN).
REQ-013 IDLE: din_ready=1, x_valid=0, x=0, busy=0; on acceptance go to SHIFT.
REQ-014 Latency: the first bit, din[WIDTH-1], appears on x with x_valid=1 in the cycle immediately after the acceptance edge.
REQ-015 Bit order: MSB first; one bit per clock; exactly WIDTH consecutive x_valid=1 cycles per word.
REQ-016 Bit counter: counts WIDTH-1 down to 0; the last data bit is the cycle where counter=0.
REQ-017 SHIFT, last bit, no parity: din_ready=1; acceptance reloads the shifter and stays in SHIFT (gapless back-to-back); otherwise go to IDLE.
REQ-018 SHIFT, not last bit: din_ready=0; din_valid ignored.
REQ-019 Upstream holding din_valid=1 while din_ready=0 causes no loss and no duplication; the word is taken at the next ready edge.
REQ-020 busy=1 exactly when x_valid=1.
REQ-021 When x_valid=0, x=0.

Reset
REQ-022 rst=1 at a rising edge forces IDLE, counter=WIDTH-1, shifter=0, x=0, x_valid=0, busy=0, regardless of din_valid.
REQ-023 Reset mid-word discards the partial word; no further bits of it are emitted.
REQ-024 While rst=1, din_ready=0 and no word is accepted; the first acceptance can occur on the edge after rst deasserts.

Configuration
REQ-025 Macro SER_PARITY_EN: when defined, an even-parity trailer bit (XOR of all WIDTH data bits) follows the last data bit in state PAR, with x_valid=1.
REQ-026 With SER_PARITY_EN: din_ready=0 on the last data bit and =1 in PAR; acceptance in PAR goes to SHIFT gaplessly; each word occupies WIDTH+1 valid cycles.
REQ-027 Without SER_PARITY_EN: no PAR state and no parity logic; behaviour is exactly REQ-017.

Verification
REQ-028 WIDTH=8, din=8'hA5 accepted once -> next 8 cycles x=1,0,1,0,0,1,0,1 with x_valid=1, then x_valid=0, x=0.
REQ-029 8'h0F then 8'hF0 with din_valid held high -> 16 contiguous x_valid cycles, x=0000111111110000, exactly two acceptances.
REQ-030 din_valid=1 held through a word -> din_ready=0 for cycles 1..7 of the word, no extra acceptance; the new word starts right after bit 8.
REQ-031 rst pulsed during bit 4 of 8'hFF -> x_valid=0 from the next cycle; the following accepted 8'h81 emits 1,0,0,0,0,0,0,1 cleanly.
REQ-032 SER_PARITY_EN, din=8'hA5 -> 9 valid bits, trailer=0; din=8'h07 -> trailer=1.
REQ-033 Serializer output driving the sequence detector's x input with its reset released -> detector's z matches a golden model bit-for-bit over a 64-bit random stream.
